// File: rtl/adder_prefix_pipe_if.sv
// Operand/result handshake bundle for adder_prefix_pipe.
// ovf is carried only when ADDER_PREFIX_PIPE_OVF_EN is defined.
interface adder_prefix_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef ADDER_PREFIX_PIPE_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/adder_prefix_pipe.sv
// Pipelined Sklansky prefix adder with global-stall valid/ready flow.
// Optional signed-overflow output: define ADDER_PREFIX_PIPE_OVF_EN.
module adder_prefix_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1
) (
    input logic              clk,
    input logic              rst_n,
    adder_prefix_pipe_if.slave bus
);
    localparam int L  = $clog2(WIDTH);
    localparam int NV = STAGES + 2;

    typedef logic [WIDTH-1:0] vec_t;

    // Returns the internal register index placed after level m, or 0.
    function automatic int reg_at(int m);
        int r;
        r = 0;
        for (int k = 1; k <= STAGES; k++) begin
            if ((k * L) / (STAGES + 1) == m) r = k;
        end
        return r;
    endfunction

    function automatic vec_t sk_g(vec_t g, vec_t p, int lvl);
        vec_t o;
        int   j;
        o = g;
        for (int i = 0; i < WIDTH; i++) begin
            if (((i >> lvl) & 1) == 1) begin
                j    = ((i >> lvl) << lvl) - 1;
                o[i] = g[i] | (p[i] & g[j]);
            end
        end
        return o;
    endfunction

    function automatic vec_t sk_p(vec_t p, int lvl);
        vec_t o;
        int   j;
        o = p;
        for (int i = 0; i < WIDTH; i++) begin
            if (((i >> lvl) & 1) == 1) begin
                j    = ((i >> lvl) << lvl) - 1;
                o[i] = p[i] & p[j];
            end
        end
        return o;
    endfunction

    logic [NV-1:0] v;
    logic          adv;
    vec_t          a_q;
    vec_t          b_q;
    logic          cin_q;

    vec_t lv_g [0:L];
    vec_t lv_p [0:L-1];
    vec_t lv_x [0:L];
    logic lv_c [0:L];
    vec_t in_g [1:L];
    vec_t in_p [1:L];
    vec_t in_x [1:L];
    logic in_c [1:L];

    assign adv           = !v[NV-1] | bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = v[NV-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
        end else if (adv) begin
            v <= {v[NV-2:0], bus.in_valid};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
        end else if (adv) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            cin_q <= bus.cin;
        end
    end

    // Carry-in folds into bit 0 as the generate of a virtual bit -1.
    assign lv_x[0] = a_q ^ b_q;
    assign lv_p[0] = a_q ^ b_q;
    assign lv_g[0] = (a_q & b_q) | vec_t'((a_q[0] ^ b_q[0]) & cin_q);
    assign lv_c[0] = cin_q;

    for (genvar l = 1; l <= L; l++) begin : gen_lvl
        localparam int K = reg_at(l - 1);
        if (K != 0) begin : gen_reg
            vec_t rg;
            vec_t rp;
            vec_t rx;
            logic rc;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rg <= '0;
                    rp <= '0;
                    rx <= '0;
                    rc <= 1'b0;
                end else if (adv) begin
                    rg <= lv_g[l-1];
                    rp <= lv_p[l-1];
                    rx <= lv_x[l-1];
                    rc <= lv_c[l-1];
                end
            end
            assign in_g[l] = rg;
            assign in_p[l] = rp;
            assign in_x[l] = rx;
            assign in_c[l] = rc;
        end else begin : gen_wire
            assign in_g[l] = lv_g[l-1];
            assign in_p[l] = lv_p[l-1];
            assign in_x[l] = lv_x[l-1];
            assign in_c[l] = lv_c[l-1];
        end
        assign lv_g[l] = sk_g(in_g[l], in_p[l], l - 1);
        if (l < L) begin : gen_p
            assign lv_p[l] = sk_p(in_p[l], l - 1);
        end
        assign lv_x[l] = in_x[l];
        assign lv_c[l] = in_c[l];
    end

    vec_t g_f;
    vec_t sum_n;
    vec_t sum_q;
    logic cout_q;

    assign g_f   = lv_g[L];
    assign sum_n = lv_x[L] ^ {g_f[WIDTH-2:0], lv_c[L]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (adv) begin
            sum_q  <= sum_n;
            cout_q <= g_f[WIDTH-1];
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

`ifdef ADDER_PREFIX_PIPE_OVF_EN
    logic ovf_q;

    // Carry into the MSB is the prefix generate of bits [WIDTH-2:0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= g_f[WIDTH-1] ^ g_f[WIDTH-2];
        end
    end

    assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_adder_prefix_pipe.sv
// Randomized scoreboard bench for adder_prefix_pipe.
// Reference results come from plain wide-integer addition.
module tb_adder_prefix_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1
);
    localparam int W = WIDTH;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    exp_t exp_q [$];
    logic took       = 1'b0;
    logic stall_prev = 1'b0;
    logic [W-1:0] hold_sum;
    logic         hold_cout;

    adder_prefix_pipe_if #(.WIDTH(W)) bus ();

    adder_prefix_pipe #(
        .WIDTH (W),
        .STAGES(STAGES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y,
                                   logic c);
        exp_t         e;
        logic [W:0]   full;
        logic [W-1:0] lo;
        full = {1'b0, x} + {1'b0, y} + (W+1)'(c);
        lo   = {1'b0, x[W-2:0]} + {1'b0, y[W-2:0]} + W'(c);
        e.s  = full[W-1:0];
        e.c  = full[W];
        e.o  = lo[W-1] ^ full[W];
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic fo;
        logic fi;
        if (!rst_n) begin
            exp_q.delete();
            took       = 1'b0;
            stall_prev = 1'b0;
        end else begin
            fo = bus.out_valid & bus.out_ready;
            fi = bus.in_valid & bus.in_ready;
            if (stall_prev && bus.out_valid) begin
                chk("hold_sum", bus.sum, hold_sum);
                chk("hold_cout", bus.cout, hold_cout);
            end
            if (bus.out_valid && !bus.out_ready)
                chk("stall_in_ready", bus.in_ready, 0);
            if (fo) begin
                if (exp_q.size() == 0) begin
                    chk("underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sum", bus.sum, e.s);
                    chk("cout", bus.cout, e.c);
`ifdef ADDER_PREFIX_PIPE_OVF_EN
                    chk("ovf", bus.ovf, e.o);
`endif
                end
            end
            if (fi) exp_q.push_back(model(bus.a, bus.b, bus.cin));
            took       = fi;
            stall_prev = bus.out_valid & !bus.out_ready;
            hold_sum   = bus.sum;
            hold_cout  = bus.cout;
        end
    end

    task automatic rnd_in();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.a = t[W-1:0];
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.b = t[W-1:0];
        if ($urandom_range(0, 3) == 0) bus.b = ~bus.a;
        bus.cin = 1'($urandom_range(0, 1));
    endtask

    task automatic send_one(input logic [127:0] ta, input logic [127:0] tb_,
                            input logic tc, input logic [127:0] es,
                            input logic ec, input logic eo);
        int acc;
        @(posedge clk);
        #1;
        bus.a         = ta[W-1:0];
        bus.b         = tb_[W-1:0];
        bus.cin       = tc;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        acc = cyc;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) break;
        end
        chk("latency", cyc - acc, STAGES + 1);
        chk("dir_sum", bus.sum, es);
        chk("dir_cout", bus.cout, ec);
`ifdef ADDER_PREFIX_PIPE_OVF_EN
        chk("dir_ovf", bus.ovf, eo);
`else
        if (eo === 1'bx) chk("dir_ovf_arg", eo, 0);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] half;
        logic [W-1:0] msb;
        int first;
        int last;
        int cnt;
        ones = '1;
        half = ones >> 1;
        msb  = ~half;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_sum", bus.sum, 0);
        chk("rst_cout", bus.cout, 0);
        chk("rst_in_ready", bus.in_ready, 1);
`ifdef ADDER_PREFIX_PIPE_OVF_EN
        chk("rst_ovf", bus.ovf, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        send_one(3, 4, 1'b1, 8, 1'b0, 1'b0);
        send_one(ones, 0, 1'b1, 0, 1'b1, 1'b0);
        send_one(half, 1, 1'b0, msb, 1'b0, 1'b1);
        send_one(msb, msb, 1'b0, 0, 1'b1, 1'b1);
        idle(STAGES + 4);

        first = -1;
        last  = -1;
        cnt   = 0;
        for (int i = 0; i < 100 + STAGES + 3; i++) begin
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
            if (i < 100) begin
                rnd_in();
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            if (bus.out_valid) begin
                cnt++;
                if (first < 0) first = i;
                last = i;
            end
        end
        chk("stream_cnt", cnt, 100);
        chk("stream_run", last - first + 1, 100);
        chk("stream_drain", exp_q.size(), 0);

        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (!bus.in_valid || took) rnd_in();
            bus.in_valid  = 1'b1;
            bus.out_ready = !(i >= 6 && i < 11);
        end
        @(posedge clk);
        #1;
        if (!took && bus.in_valid) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        idle(STAGES + 6);
        chk("stall_drain", exp_q.size(), 0);

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            rnd_in();
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_sum", bus.sum, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        send_one(100, 23, 1'b0, 123, 1'b0, 1'b0);
        idle(STAGES + 4);
        chk("rst_drain", exp_q.size(), 0);

        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (!bus.in_valid || took) begin
                rnd_in();
                bus.in_valid = ($urandom_range(0, 9) < 7);
            end
            bus.out_ready = ($urandom_range(0, 9) < 6);
        end
        @(posedge clk);
        #1;
        if (!took && bus.in_valid) begin
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        idle(STAGES + 8);
        chk("rand_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
